// File: rtl/rv_pipe_pkg.sv
// ============================================================================
// Module  : rv_pipe_pkg
// Brief   : Shared types and helpers for the RV32I hazard scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pipe_pkg;

    localparam int REG_W = 5;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } sb_entry_t;

    // Width of a forwarding select able to name stages 0..nstage-1.
    function automatic int fwd_w(input int nstage);
        return (nstage < 2) ? 1 : $clog2(nstage);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv_hazard_scoreboard_if.sv
// ============================================================================
// Module  : rv_hazard_scoreboard_if
// Brief   : ID-stage request / hazard response bundle for the scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv_hazard_scoreboard_if
    import rv_pipe_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int CNT_W  = 32
);
    localparam int c_SEL_W = fwd_w(NSTAGE);

    logic               id_valid;
    logic [REG_W-1:0]   id_rs1;
    logic [REG_W-1:0]   id_rs2;
    logic               id_rs1_used;
    logic               id_rs2_used;
    logic [REG_W-1:0]   id_rd;
    logic               id_we;
    logic               id_is_load;
    logic               flush;
    logic               stall;
    logic               issue;
    logic [c_SEL_W-1:0] fwd_sel1;
    logic [c_SEL_W-1:0] fwd_sel2;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   issue_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_we, id_is_load, flush,
        input  stall, issue, fwd_sel1, fwd_sel2, stall_cnt, issue_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_we, id_is_load, flush,
        output stall, issue, fwd_sel1, fwd_sel2, stall_cnt, issue_cnt
    );

endinterface

`default_nettype wire

// File: rtl/rv_sb_match.sv
// ============================================================================
// Module  : rv_sb_match
// Brief   : Youngest-producer search for one source operand. Forwarding
//           behaviour selected by RV_FWD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_sb_match
    import rv_pipe_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int LD_STAGE = 2
) (
    input  wire logic [REG_W-1:0]          i_rs,
    input  wire logic                      i_used,
    input  wire sb_entry_t [NSTAGE-1:0]    i_entries,
    output logic                           o_hazard,
    output logic [fwd_w(NSTAGE)-1:0]       o_k
);
    localparam int c_SEL_W = fwd_w(NSTAGE);

    // Scan oldest to youngest so the youngest match overwrites the result.
    always_comb begin
        o_hazard = 1'b0;
        o_k      = '0;
        for (int s = NSTAGE - 1; s >= 0; s--) begin
            if (i_entries[s].valid && i_entries[s].we &&
                (i_entries[s].rd == i_rs) && (i_rs != '0) && i_used) begin
`ifdef RV_FWD_EN
                if (s == NSTAGE - 1) begin
                    o_hazard = 1'b0;
                    o_k      = '0;
                end else if (i_entries[s].is_load && (s + 1 < LD_STAGE)) begin
                    o_hazard = 1'b1;
                    o_k      = '0;
                end else begin
                    o_hazard = 1'b0;
                    o_k      = c_SEL_W'(s + 1);
                end
`else
                o_hazard = (s <= NSTAGE - 2);
                o_k      = '0;
`endif
            end
        end
    end

`ifndef RV_FWD_EN
    logic [NSTAGE-1:0] w_unused_load;
    logic              w_unused_cfg;
    for (genvar g = 0; g < NSTAGE; g++) begin : g_unused_load
        assign w_unused_load[g] = i_entries[g].is_load;
    end
    assign w_unused_cfg = (LD_STAGE > 0);
`endif

endmodule

`default_nettype wire

// File: rtl/rv_hazard_scoreboard.sv
// ============================================================================
// Module  : rv_hazard_scoreboard
// Brief   : In-flight destination scoreboard: RAW/load-use stall, registered
//           EX forwarding selects, flush kill. Option macro: RV_FWD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_hazard_scoreboard
    import rv_pipe_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int LD_STAGE = 2,
    parameter int CNT_W    = 32
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    rv_hazard_scoreboard_if.slave  sb
);
    localparam int c_SEL_W = fwd_w(NSTAGE);

    sb_entry_t [NSTAGE-1:0] r_stage;
    sb_entry_t              w_id_entry;
    logic                   w_haz1;
    logic                   w_haz2;
    logic [c_SEL_W-1:0]     w_k1;
    logic [c_SEL_W-1:0]     w_k2;
    logic                   w_stall;
    logic                   w_issue;
    logic [CNT_W-1:0]       r_stall_cnt;
    logic [CNT_W-1:0]       r_issue_cnt;

    rv_sb_match #(.NSTAGE(NSTAGE), .LD_STAGE(LD_STAGE)) u_match_rs1 (
        .i_rs      (sb.id_rs1),
        .i_used    (sb.id_rs1_used),
        .i_entries (r_stage),
        .o_hazard  (w_haz1),
        .o_k       (w_k1)
    );

    rv_sb_match #(.NSTAGE(NSTAGE), .LD_STAGE(LD_STAGE)) u_match_rs2 (
        .i_rs      (sb.id_rs2),
        .i_used    (sb.id_rs2_used),
        .i_entries (r_stage),
        .o_hazard  (w_haz2),
        .o_k       (w_k2)
    );

    // Reset and flush both suppress stall; flush alone still blocks issue.
    assign w_stall = ~RST & sb.id_valid & ~sb.flush & (w_haz1 | w_haz2);
    assign w_issue = ~RST & sb.id_valid & ~sb.flush & ~w_stall;

    assign w_id_entry = '{valid: 1'b1, rd: sb.id_rd, we: sb.id_we,
                          is_load: sb.id_is_load};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= w_issue ? w_id_entry : sb_entry_t'('0);
            for (int s = 1; s < NSTAGE; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

`ifdef RV_FWD_EN
    logic [c_SEL_W-1:0] r_fwd_sel1;
    logic [c_SEL_W-1:0] r_fwd_sel2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fwd_sel1 <= '0;
            r_fwd_sel2 <= '0;
        end else begin
            r_fwd_sel1 <= w_issue ? w_k1 : '0;
            r_fwd_sel2 <= w_issue ? w_k2 : '0;
        end
    end

    assign sb.fwd_sel1 = r_fwd_sel1;
    assign sb.fwd_sel2 = r_fwd_sel2;
`else
    logic w_unused_k;
    assign w_unused_k  = ^{w_k1, w_k2};
    assign sb.fwd_sel1 = '0;
    assign sb.fwd_sel2 = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_issue && (r_issue_cnt != '1)) r_issue_cnt <= r_issue_cnt + 1'b1;
        end
    end

    assign sb.stall     = w_stall;
    assign sb.issue     = w_issue;
    assign sb.stall_cnt = r_stall_cnt;
    assign sb.issue_cnt = r_issue_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rv_hazard_scoreboard.sv
// ============================================================================
// Module  : tb_rv_hazard_scoreboard
// Brief   : Directed self-checking bench for rv_hazard_scoreboard (defaults).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_hazard_scoreboard;

`ifdef RV_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif
    localparam int c_ALU_ST = c_FWD ? 0 : 2;
    localparam int c_LD_ST  = c_FWD ? 1 : 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    int   exp_issue;
    int   exp_stall;

    rv_hazard_scoreboard_if #(.NSTAGE(3), .CNT_W(32)) sb_if ();

    rv_hazard_scoreboard #(.NSTAGE(3), .LD_STAGE(2), .CNT_W(32)) dut (
        .CLK (clk),
        .RST (rst),
        .sb  (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld, input logic fl);
        sb_if.id_valid    = v;
        sb_if.id_rs1      = rs1;
        sb_if.id_rs1_used = u1;
        sb_if.id_rs2      = rs2;
        sb_if.id_rs2_used = u2;
        sb_if.id_rd       = rd;
        sb_if.id_we       = we;
        sb_if.id_is_load  = ld;
        sb_if.flush       = fl;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) step();
    endtask

    // Hold an instruction in ID until it issues; returns just after the issue edge.
    task automatic send(input string tag, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld, input int exp_st);
        int  nst;
        bit  done;
        nst  = 0;
        done = 1'b0;
        set_id(1'b1, rs1, u1, rs2, u2, rd, we, ld, 1'b0);
        #1;
        for (int i = 0; i < 8 && !done; i++) begin
            if (sb_if.issue === 1'b1) begin
                done = 1'b1;
            end else begin
                chk({tag, "_stall_hi"}, {31'd0, sb_if.stall}, 32'd1);
                nst++;
            end
            step();
        end
        chk({tag, "_issued"}, {31'd0, done}, 32'd1);
        chk({tag, "_nstall"}, nst, exp_st);
        exp_issue += 1;
        exp_stall += exp_st;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        exp_issue = 0;
        exp_stall = 0;
        rst       = 1'b1;
        set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rst_stall", {31'd0, sb_if.stall}, 32'd0);
        chk("rst_issue", {31'd0, sb_if.issue}, 32'd0);
        repeat (2) step();
        rst = 1'b0;
        idle(1);
        chk("rst_fwd1", {30'd0, sb_if.fwd_sel1}, 32'd0);
        chk("rst_fwd2", {30'd0, sb_if.fwd_sel2}, 32'd0);
        chk("rst_scnt", sb_if.stall_cnt, 32'd0);
        chk("rst_icnt", sb_if.issue_cnt, 32'd0);

        // addi x1,x0 ; add x2,x1,x1
        send("alu_p", 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 0);
        send("alu_c", 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, c_ALU_ST);
        chk("alu_fwd1", {30'd0, sb_if.fwd_sel1}, c_FWD ? 32'd1 : 32'd0);
        chk("alu_fwd2", {30'd0, sb_if.fwd_sel2}, c_FWD ? 32'd1 : 32'd0);
        idle(3);
        chk("alu_icnt", sb_if.issue_cnt, 32'd2);
        chk("alu_scnt", sb_if.stall_cnt, c_ALU_ST);

        // lw x5 ; add x6,x5,x0
        send("ld_p", 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 0);
        send("ld_c", 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, c_LD_ST);
        chk("ld_fwd1", {30'd0, sb_if.fwd_sel1}, c_FWD ? 32'd2 : 32'd0);
        chk("ld_fwd2", {30'd0, sb_if.fwd_sel2}, 32'd0);
        idle(3);
        chk("ld_scnt", sb_if.stall_cnt, exp_stall);
        chk("ld_icnt", sb_if.issue_cnt, exp_issue);

        // x0 producer/consumer, then unused rs2 matching a producer
        send("x0_p", 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 0);
        send("x0_c", 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 0);
        chk("x0_fwd1", {30'd0, sb_if.fwd_sel1}, 32'd0);
        chk("x0_fwd2", {30'd0, sb_if.fwd_sel2}, 32'd0);
        idle(3);
        send("nu_p", 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 0);
        send("nu_c", 5'd0, 1'b1, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0, 0);
        chk("nu_fwd2", {30'd0, sb_if.fwd_sel2}, 32'd0);
        idle(3);

        // lw x5 ; lw x9,(x5) killed by flush ; add x10,x9 must not see x9
        send("fl_p", 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 0);
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1);
        #1;
        chk("fl_stall", {31'd0, sb_if.stall}, 32'd0);
        chk("fl_issue", {31'd0, sb_if.issue}, 32'd0);
        step();
        chk("fl_fwd1", {30'd0, sb_if.fwd_sel1}, 32'd0);
        send("fl_c", 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 0);
        chk("fl_cfwd1", {30'd0, sb_if.fwd_sel1}, 32'd0);
        idle(3);
        chk("fl_scnt", sb_if.stall_cnt, exp_stall);
        chk("fl_icnt", sb_if.issue_cnt, exp_issue);

        // lw x3 ; addi x3,x0 ; add x4,x3,x0 -> youngest producer wins
        send("yw_ld", 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 0);
        send("yw_alu", 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 0);
        send("yw_c", 5'd3, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, c_ALU_ST);
        chk("yw_fwd1", {30'd0, sb_if.fwd_sel1}, c_FWD ? 32'd1 : 32'd0);
        idle(3);
        chk("yw_scnt", sb_if.stall_cnt, exp_stall);

        // Reset with a load in EX and a dependent in ID
        send("rr_p", 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 0);
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rr_stall_in", {31'd0, sb_if.stall}, 32'd0);
        chk("rr_issue_in", {31'd0, sb_if.issue}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rr_stall", {31'd0, sb_if.stall}, 32'd0);
        chk("rr_issue", {31'd0, sb_if.issue}, 32'd1);
        chk("rr_scnt", sb_if.stall_cnt, 32'd0);
        chk("rr_icnt", sb_if.issue_cnt, 32'd0);
        step();
        chk("rr_icnt1", sb_if.issue_cnt, 32'd1);
        chk("rr_fwd1", {30'd0, sb_if.fwd_sel1}, 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv_hazard_scoreboard.md
# rv_hazard_scoreboard

Parametrised in-flight register scoreboard for the RV32I pipeline. It tracks destination registers of every instruction past ID and raises a load-use/RAW stall toward IF/ID. It also generates registered forwarding selects for the EX operand muxes and kills the ID instruction on a branch flush. It replaces the fixed, hazard-unaware ID→EX→MEM→WB chain and lets the pipeline depth change without rewriting hazard logic.

## Interface
- NSTAGE, 3: in-flight stages after ID (index 0 = EX, NSTAGE-1 = WB); legal 2..8
- LD_STAGE, 2: first stage index whose output register holds load data; legal 1..NSTAGE-1
- CNT_W, 32: width of performance counters
- CLK  in  1  clock; all state on rising edge
- RST  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  5  source register numbers
- id_rs1_used, id_rs2_used  in  1  source actually read by the instruction
- id_rd  in  5  destination register
- id_we  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
- stall  out  1  hold PC and IF/ID register (combinational)
- issue  out  1  ID instruction enters EX this cycle (combinational)
- fwd_sel1, fwd_sel2  out  $clog2(NSTAGE)  EX operand source: 0 = ID/EX register, k = output register of stage k (registered)
- stall_cnt, issue_cnt  out  CNT_W  saturating performance counters

## Operation
- Each stage entry holds {valid, rd, we, is_load}. Entries shift one stage every cycle unconditionally; the entry leaving stage NSTAGE-1 is discarded.
- Stage 0 loads the ID entry when issue=1, else a bubble (valid=0).
- Producer match for source rsN at stage s: entry.valid & entry.we & entry.rd==rsN & rsN!=0 & rsN_used.
- The youngest match (smallest s) decides. Older matches are ignored.
- With forwarding enabled:
  - A match at s=NSTAGE-1 needs no action; the register file is write-through.
  - A load match with s+1 < LD_STAGE is a hazard.
  - Any other match sets the forward source k = s+1.
- stall = id_valid & ~flush & hazard(rs1 | rs2).
- issue = id_valid & ~flush & ~stall.
- On issue, fwd_sel1/fwd_sel2 are loaded with k (0 if no match). Otherwise they are loaded with 0.
- Flush priority: flush wins over stall; stall=0, issue=0, stage 0 gets a bubble. Entries already in EX and beyond are not affected.
- stall_cnt increments on every stall cycle; issue_cnt increments on every issue. Both hold at all-ones and never wrap.

## Timing
- stall and issue are combinational from ID inputs and the current stage entries, with no cycle of latency.
- fwd_sel is valid in the cycle the consumer occupies EX, one cycle after issue.
- With defaults (NSTAGE=3, LD_STAGE=2):
  - ALU→ALU back-to-back: no stall, fwd_sel=1.
  - Load→use back-to-back: exactly 1 stall cycle, then fwd_sel=2.
- Reset: all entries invalid; fwd_sel1=fwd_sel2=0; stall_cnt=issue_cnt=0.
- While RST=1: stall=0 and issue=0 regardless of inputs.
- Reset asserted mid-operation drops all in-flight entries on that edge.

## Configuration
- RV_FWD_EN defined: forwarding as described above.
- RV_FWD_EN undefined:
  - fwd_sel1/fwd_sel2 are tied to 0.
  - Any match at s ≤ NSTAGE-2 is a hazard, so the consumer waits until the producer reaches WB.
  - With defaults, an ALU→ALU back-to-back pair gives 2 stall cycles.

## Structure
- Package rv_pipe_pkg:
  - REG_W=5
  - sb_entry_t struct {valid, rd, we, is_load}
  - function fwd_w(NSTAGE) returning the select width
- Sub-module rv_sb_match:
  - takes one source number, its used bit and the entry vector
  - returns hazard and k
  - instantiated twice, once per source operand
- Top holds the entry shift register, fwd_sel registers and counters.

## Test plan
- After reset, addi x1 then add x2,x1,x1 back-to-back → stall never asserted; fwd_sel1=fwd_sel2=1 when add is in EX; issue_cnt=2.
- lw x5 then add x6,x5,x0 → stall=1 for exactly 1 cycle, stall_cnt=1; then fwd_sel1=2, fwd_sel2=0.
- Producer writes x0, consumer reads x0; separately, a consumer with rs2_used=0 on a matching rs2 → no stall, fwd_sel=0.
- Load-use stall cycle with flush=1 in the same cycle → stall=0, issue=0, bubble enters EX; stall_cnt unchanged.
- Two producers of x3 (ALU in EX, older load in MEM), then a consumer of x3 → youngest wins, fwd_sel1=1. Without RV_FWD_EN, the same sequence gives 2 stall cycles and fwd_sel1=0.
- RST pulsed with a load in EX and a dependent in ID → next cycle: no stall, all entries empty, counters 0.
